// File: rtl/pipe_hazard_if.sv
// Hazard-control bus between the pipeline datapath (master) and the hazard
// controller (slave): decoded hazard sources in, stage enables/flushes and event counters out.
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_regdest;
    logic             ex_redirect;
    logic             mem_busy;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] freeze_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_regdest, ex_redirect, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
        input  state, stall_cnt, flush_cnt, freeze_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_regdest, ex_redirect, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
        output state, stall_cnt, flush_cnt, freeze_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, redirect flushes and
// memory-wait freezes, with saturating event counters.
module pipe_hazard_ctrl #(
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic         clock,
    input  logic         reset,
    pipe_hazard_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } state_e;

    localparam logic [1:0] REMAIN_INIT = 2'(LOAD_USE_STALL - 1);

    state_e           state_q, state_d;
    state_e           saved_q, saved_d;
    state_e           eff_state;
    logic [1:0]       remain_q, remain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic             lu;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Register $0 never creates a dependency.
    assign lu = bus.ex_memread && (bus.ex_regdest != 5'd0) &&
                ((bus.ex_regdest == bus.id_rs) ||
                 (bus.id_uses_rt && (bus.ex_regdest == bus.id_rt)));

    // Leaving FREEZE resumes the interrupted state's behaviour in the same cycle.
    assign eff_state = (state_q == FREEZE) ? saved_q : state_q;

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        state_d      = state_q;
        saved_d      = saved_q;
        remain_d     = remain_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;

        if (reset) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (bus.mem_busy) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            freeze_cnt_d = sat_inc(freeze_cnt_q);
            state_d      = FREEZE;
            if (state_q != FREEZE) saved_d = state_q;
        end else if (eff_state == STALL) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
            stall_cnt_d = sat_inc(stall_cnt_q);
            remain_d    = remain_q - 2'd1;
            state_d     = (remain_q == 2'd1) ? RUN : STALL;
        end else if (bus.ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
            state_d     = RUN;
        end else if (lu) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
            stall_cnt_d = sat_inc(stall_cnt_q);
            if (LOAD_USE_STALL == 1) begin
                state_d = RUN;
            end else begin
                state_d  = STALL;
                remain_d = REMAIN_INIT;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RUN;
            saved_q      <= RUN;
            remain_q     <= 2'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            remain_q     <= remain_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign bus.pc_en      = pc_en;
    assign bus.ifid_en    = ifid_en;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_en    = idex_en;
    assign bus.idex_flush = idex_flush;
    assign bus.exmem_en   = exmem_en;
    assign bus.memwb_en   = memwb_en;
    assign bus.state      = state_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
    assign bus.freeze_cnt = freeze_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (1-bubble, 3-bubble,
// 2-bit counters) share one stimulus stream; each step checks the relevant instance.
module tb_pipe_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    pipe_hazard_if #(.CNT_W(16)) b1 ();
    pipe_hazard_if #(.CNT_W(16)) b3 ();
    pipe_hazard_if #(.CNT_W(2))  bc ();

    pipe_hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(16)) u1 (.clock(clock), .reset(reset), .bus(b1));
    pipe_hazard_ctrl #(.LOAD_USE_STALL(3), .CNT_W(16)) u3 (.clock(clock), .reset(reset), .bus(b3));
    pipe_hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(2))  uc (.clock(clock), .reset(reset), .bus(bc));

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic mr, input logic [4:0] rd, input logic redir, input logic busy);
        b1.id_rs = rs; b1.id_rt = rt; b1.id_uses_rt = urt; b1.ex_memread = mr;
        b1.ex_regdest = rd; b1.ex_redirect = redir; b1.mem_busy = busy;
        b3.id_rs = rs; b3.id_rt = rt; b3.id_uses_rt = urt; b3.ex_memread = mr;
        b3.ex_regdest = rd; b3.ex_redirect = redir; b3.mem_busy = busy;
        bc.id_rs = rs; bc.id_rt = rt; bc.id_uses_rt = urt; bc.ex_memread = mr;
        bc.ex_regdest = rd; bc.ex_redirect = redir; bc.mem_busy = busy;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        // Reset outputs, with mem_busy showing reset takes priority.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("rst_pc_en", 32'(b1.pc_en), 0);
        chk("rst_ifid_en", 32'(b1.ifid_en), 1);
        chk("rst_memwb_en", 32'(b1.memwb_en), 1);
        chk("rst_ifid_flush", 32'(b1.ifid_flush), 1);
        chk("rst_idex_flush", 32'(b1.idex_flush), 1);
        tick();
        chk("rst_state", 32'(b1.state), 0);
        chk("rst_freeze_cnt", 32'(b1.freeze_cnt), 0);
        chk("rst_stall_cnt", 32'(b1.stall_cnt), 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("run_pc_en", 32'(b1.pc_en), 1);
        chk("run_idex_flush", 32'(b1.idex_flush), 0);

        // Single-bubble load-use on rs.
        drive(5, 0, 0, 1, 5, 0, 0);
        chk("lu1_pc_en", 32'(b1.pc_en), 0);
        chk("lu1_ifid_en", 32'(b1.ifid_en), 0);
        chk("lu1_idex_en", 32'(b1.idex_en), 1);
        chk("lu1_idex_flush", 32'(b1.idex_flush), 1);
        chk("lu1_ifid_flush", 32'(b1.ifid_flush), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lu1_after_pc_en", 32'(b1.pc_en), 1);
        chk("lu1_after_ifid_en", 32'(b1.ifid_en), 1);
        chk("lu1_after_state", 32'(b1.state), 0);
        chk("lu1_stall_cnt", 32'(b1.stall_cnt), 1);
        do_reset();

        // $0 destination and unused rt never stall; used rt does.
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("lu_r0_pc_en", 32'(b1.pc_en), 1);
        tick();
        drive(3, 7, 0, 1, 7, 0, 0);
        chk("lu_rt_unused_pc_en", 32'(b1.pc_en), 1);
        tick();
        chk("lu_none_stall_cnt", 32'(b1.stall_cnt), 0);
        drive(3, 7, 1, 1, 7, 0, 0);
        chk("lu_rt_used_pc_en", 32'(b1.pc_en), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lu_rt_stall_cnt", 32'(b1.stall_cnt), 1);
        do_reset();

        // Redirect beats a simultaneous load-use.
        drive(5, 0, 0, 1, 5, 1, 0);
        chk("redir_pc_en", 32'(b1.pc_en), 1);
        chk("redir_ifid_en", 32'(b1.ifid_en), 1);
        chk("redir_ifid_flush", 32'(b1.ifid_flush), 1);
        chk("redir_idex_flush", 32'(b1.idex_flush), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("redir_flush_cnt", 32'(b1.flush_cnt), 1);
        chk("redir_stall_cnt", 32'(b1.stall_cnt), 0);
        do_reset();

        // Three-bubble stall frozen for two cycles starting at the second bubble.
        drive(5, 0, 0, 1, 5, 0, 0);
        chk("s3_b1_pc_en", 32'(b3.pc_en), 0);
        tick();
        chk("s3_state_a", 32'(b3.state), 1);
        drive(5, 0, 0, 1, 5, 1, 1);
        chk("s3_frz_pc_en", 32'(b3.pc_en), 0);
        chk("s3_frz_idex_en", 32'(b3.idex_en), 0);
        chk("s3_frz_memwb_en", 32'(b3.memwb_en), 0);
        chk("s3_frz_idex_flush", 32'(b3.idex_flush), 0);
        tick();
        chk("s3_state_b", 32'(b3.state), 2);
        tick();
        chk("s3_state_c", 32'(b3.state), 2);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("s3_resume_pc_en", 32'(b3.pc_en), 0);
        chk("s3_resume_idex_flush", 32'(b3.idex_flush), 1);
        chk("s3_resume_ifid_flush", 32'(b3.ifid_flush), 0);
        tick();
        chk("s3_state_d", 32'(b3.state), 1);
        tick();
        chk("s3_state_e", 32'(b3.state), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("s3_done_pc_en", 32'(b3.pc_en), 1);
        chk("s3_stall_cnt", 32'(b3.stall_cnt), 3);
        chk("s3_freeze_cnt", 32'(b3.freeze_cnt), 2);
        chk("s3_flush_cnt", 32'(b3.flush_cnt), 0);
        do_reset();

        // 2-bit flush counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            tick();
            chk("sat_flush_cnt", 32'(bc.flush_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("sat_flush_hold", 32'(bc.flush_cnt), 3);
        do_reset();

        // Reset in STALL drops pending bubbles.
        drive(5, 0, 0, 1, 5, 0, 0);
        tick();
        chk("rs_state_stall", 32'(b3.state), 1);
        chk("rs_stall_cnt_pre", 32'(b3.stall_cnt), 1);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rs_pc_en", 32'(b3.pc_en), 0);
        chk("rs_ifid_en", 32'(b3.ifid_en), 1);
        tick();
        chk("rs_state", 32'(b3.state), 0);
        chk("rs_stall_cnt", 32'(b3.stall_cnt), 0);
        reset = 1'b0;
        #1;
        chk("rs_release_pc_en", 32'(b3.pc_en), 1);
        chk("rs_release_idex_flush", 32'(b3.idex_flush), 0);
        tick();
        chk("rs_release_state", 32'(b3.state), 0);
        chk("rs_release_stall_cnt", 32'(b3.stall_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
